// File: rtl/ibex_pext_ex_ctrl_if.sv
// Handshake and datapath bundle between the Pext execute-stage sequencer and its
// neighbours (ID, the Pext ALU, writeback and the vxsat CSR).
interface ibex_pext_ex_ctrl_if;
  logic              instr_valid;
  logic              instr_multicycle;
  logic              mult_sel;
  logic              div_sel;
  logic [4:0]        rd_addr;
  logic              ex_ready;
  logic              flush;
  logic              mult_en;
  logic              div_en;
  logic              multdiv_ready_id;
  logic              alu_valid;
  logic [31:0]       alu_result;
  logic              alu_set_ov;
  logic [1:0]        imd_val_we;
  logic [1:0][33:0]  imd_val_d;
  logic [1:0][33:0]  imd_val_q;
  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_result;
  logic [4:0]        wb_rd_addr;
  logic              vxsat_we;
  logic              vxsat_wdata;
  logic              vxsat;
  logic              timeout;

  modport slave (
    input  instr_valid, instr_multicycle, mult_sel, div_sel, rd_addr, flush,
           alu_valid, alu_result, alu_set_ov, imd_val_we, imd_val_d,
           wb_ready, vxsat_we, vxsat_wdata,
    output ex_ready, mult_en, div_en, multdiv_ready_id, imd_val_q,
           wb_valid, wb_result, wb_rd_addr, vxsat, timeout
  );

  modport master (
    output instr_valid, instr_multicycle, mult_sel, div_sel, rd_addr, flush,
           alu_valid, alu_result, alu_set_ov, imd_val_we, imd_val_d,
           wb_ready, vxsat_we, vxsat_wdata,
    input  ex_ready, mult_en, div_en, multdiv_ready_id, imd_val_q,
           wb_valid, wb_result, wb_rd_addr, vxsat, timeout
  );
endinterface

// File: rtl/ibex_pext_ex_ctrl.sv
// Execute-stage sequencer around the Pext ALU: multdiv enables, intermediate-value
// registers, registered writeback result and the sticky vxsat flag.
//
// state | meaning
// IDLE  | no op in flight, ready for a new instruction
// MULTI | multicycle mult/div running, waiting for ALU valid or watchdog expiry
// OUT   | result held toward writeback until wb_ready
module ibex_pext_ex_ctrl #(
  parameter int unsigned MAX_MULTI_CYCLES = 40
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  ibex_pext_ex_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_MULTI_CYCLES > 2) ? $clog2(MAX_MULTI_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_MULTI_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MULTI, OUT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sel_q;
  logic [4:0]       rd_q;
  logic             wb_valid_q;
  logic [31:0]      wb_result_q;
  logic [4:0]       wb_rd_q;
  logic [1:0][33:0] imd_q;
  logic             vxsat_q, vxsat_d;
  logic             timeout_q;

  logic ex_ready;
  logic accept, accept_multi, accept_single;
  logic in_multi, capture, expire, imd_en;
  logic mult_en, div_en, multdiv_ready_id;

  // Flush blocks the handshake, so every accept below is implicitly flush-free.
  assign ex_ready      = ~bus.flush & ((state_q == IDLE) | ((state_q == OUT) & bus.wb_ready));
  assign accept        = bus.instr_valid & ex_ready;
  assign accept_multi  = accept & bus.instr_multicycle;
  assign accept_single = accept & ~bus.instr_multicycle;
  assign in_multi      = (state_q == MULTI) & ~bus.flush;
  assign capture       = accept_single | (in_multi & bus.alu_valid);
  assign expire        = in_multi & ~bus.alu_valid & (cnt_q == CNT_LAST);
  assign imd_en        = accept_multi | in_multi;
  assign vxsat_d       = (bus.vxsat_we ? bus.vxsat_wdata : vxsat_q) | (capture & bus.alu_set_ov);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else if (accept_multi) begin
      state_d = MULTI;
    end else if (accept_single) begin
      state_d = OUT;
    end else begin
      case (state_q)
        MULTI:   if (bus.alu_valid) state_d = OUT;
                 else if (expire)   state_d = IDLE;
        OUT:     if (bus.wb_ready)  state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    mult_en          = 1'b0;
    div_en           = 1'b0;
    multdiv_ready_id = 1'b0;
    if (in_multi) begin
      mult_en          = sel_q[1];
      div_en           = sel_q[0];
      multdiv_ready_id = bus.alu_valid;
    end else if (accept_multi) begin
      mult_en = bus.mult_sel;
      div_en  = bus.div_sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      sel_q       <= '0;
      rd_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_rd_q     <= '0;
      imd_q       <= '0;
      vxsat_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= expire;
      vxsat_q   <= vxsat_d;

      if (bus.flush || accept_multi) cnt_q <= '0;
      else if (state_q == MULTI)     cnt_q <= cnt_q + CNT_W'(1);

      if (accept_multi) begin
        sel_q <= {bus.mult_sel, bus.div_sel};
        rd_q  <= bus.rd_addr;
      end

      if (bus.flush) begin
        wb_valid_q <= 1'b0;
      end else if (capture) begin
        wb_valid_q  <= 1'b1;
        wb_result_q <= bus.alu_result;
        wb_rd_q     <= accept_single ? bus.rd_addr : rd_q;
      end else if ((state_q == OUT) && bus.wb_ready) begin
        wb_valid_q <= 1'b0;
      end

      for (int r = 0; r < 2; r++) begin
        if (imd_en && bus.imd_val_we[r]) imd_q[r] <= bus.imd_val_d[r];
      end
    end
  end

  assign bus.ex_ready         = ex_ready;
  assign bus.mult_en          = mult_en;
  assign bus.div_en           = div_en;
  assign bus.multdiv_ready_id = multdiv_ready_id;
  assign bus.imd_val_q        = imd_q;
  assign bus.wb_valid         = wb_valid_q;
  assign bus.wb_result        = wb_result_q;
  assign bus.wb_rd_addr       = wb_rd_q;
  assign bus.vxsat            = vxsat_q;
  assign bus.timeout          = timeout_q;

endmodule

// File: tb/tb_ibex_pext_ex_ctrl.sv
// Scoreboard bench for ibex_pext_ex_ctrl: directed ops push expected writebacks,
// a negedge monitor pops them on each wb handshake.
module tb_ibex_pext_ex_ctrl;
  localparam int MAXC = 40;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        vx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ibex_pext_ex_ctrl_if bus();

  ibex_pext_ex_ctrl #(.MAX_MULTI_CYCLES(MAXC)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    bus.instr_valid      = 1'b0;
    bus.instr_multicycle = 1'b0;
    bus.mult_sel         = 1'b0;
    bus.div_sel          = 1'b0;
    bus.rd_addr          = '0;
    bus.flush            = 1'b0;
    bus.alu_valid        = 1'b0;
    bus.alu_result       = '0;
    bus.alu_set_ov       = 1'b0;
    bus.imd_val_we       = '0;
    bus.imd_val_d        = '0;
    bus.wb_ready         = 1'b1;
    bus.vxsat_we         = 1'b0;
    bus.vxsat_wdata      = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_single(input logic [31:0] res, input logic [4:0] rd, input logic ov);
    bus.instr_valid = 1'b1;
    bus.rd_addr     = rd;
    bus.alu_result  = res;
    bus.alu_set_ov  = ov;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.wb_valid && bus.wb_ready) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", {bus.wb_rd_addr, bus.wb_result}, 68'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_result", bus.wb_result, e.res);
        chk("wb_rd", bus.wb_rd_addr, e.rd);
        chk("wb_vxsat", bus.vxsat, e.vx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int  n;
    bit  seen;
    bit  wbseen;
    clr_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_result", bus.wb_result, 0);
    chk("rst_wb_rd", bus.wb_rd_addr, 0);
    chk("rst_imd", bus.imd_val_q, 0);
    chk("rst_vxsat", bus.vxsat, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_ex_ready", bus.ex_ready, 1);
    cyc();
    rst_n = 1'b1;

    // single-cycle op with overflow
    clr_in();
    issue_single(32'h8000_0000, 5'd5, 1'b1);
    sb.push_back('{32'h8000_0000, 5'd5, 1'b1});
    @(negedge clk);
    chk("s1_ex_ready", bus.ex_ready, 1);
    cyc(); clr_in();
    @(negedge clk);
    chk("s1_wb_valid", bus.wb_valid, 1);
    chk("s1_vxsat", bus.vxsat, 1);
    cyc(); clr_in();
    @(negedge clk);
    chk("s1_wb_drop", bus.wb_valid, 0);

    // CSR write of 0 alone clears vxsat
    cyc(); clr_in();
    bus.vxsat_we = 1'b1;
    cyc(); clr_in();
    @(negedge clk);
    chk("csr_clr_vxsat", bus.vxsat, 0);

    // multicycle MULL with imd traffic
    cyc(); clr_in();
    bus.instr_valid = 1'b1; bus.instr_multicycle = 1'b1; bus.mult_sel = 1'b1; bus.rd_addr = 5'd3;
    bus.imd_val_we = 2'b01; bus.imd_val_d[0] = 34'h1_0000_0001;
    @(negedge clk);
    chk("mul_en_c0", bus.mult_en, 1);
    chk("mul_div_en_c0", bus.div_en, 0);
    cyc(); clr_in();
    bus.imd_val_we = 2'b10; bus.imd_val_d[1] = 34'h2_AAAA_5555;
    @(negedge clk);
    chk("mul_en_c1", bus.mult_en, 1);
    chk("mul_imd0", bus.imd_val_q[0], 34'h1_0000_0001);
    chk("mul_ex_ready_c1", bus.ex_ready, 0);
    chk("mul_mdrdy_c1", bus.multdiv_ready_id, 0);
    cyc(); clr_in();
    @(negedge clk);
    chk("mul_en_c2", bus.mult_en, 1);
    chk("mul_imd1", bus.imd_val_q[1], 34'h2_AAAA_5555);
    cyc(); clr_in();
    bus.alu_valid = 1'b1; bus.alu_result = 32'h0000_0018;
    sb.push_back('{32'h0000_0018, 5'd3, 1'b0});
    @(negedge clk);
    chk("mul_en_c3", bus.mult_en, 1);
    chk("mul_mdrdy_c3", bus.multdiv_ready_id, 1);
    cyc(); clr_in();
    bus.imd_val_we = 2'b11; bus.imd_val_d[0] = 34'h0_BAD0_BAD0; bus.imd_val_d[1] = 34'h0_BAD1_BAD1;
    @(negedge clk);
    chk("mul_en_out", bus.mult_en, 0);
    chk("mul_wb_valid", bus.wb_valid, 1);
    cyc(); clr_in();
    @(negedge clk);
    chk("mul_imd0_hold", bus.imd_val_q[0], 34'h1_0000_0001);
    chk("mul_imd1_hold", bus.imd_val_q[1], 34'h2_AAAA_5555);

    // flush in MULTI coincident with valid/set_ov
    cyc(); clr_in();
    bus.instr_valid = 1'b1; bus.instr_multicycle = 1'b1; bus.div_sel = 1'b1; bus.rd_addr = 5'd9;
    cyc(); clr_in();
    @(negedge clk);
    chk("fl_div_en", bus.div_en, 1);
    cyc(); clr_in();
    bus.flush = 1'b1; bus.alu_valid = 1'b1; bus.alu_set_ov = 1'b1; bus.alu_result = 32'h0000_DEAD;
    bus.imd_val_we = 2'b01; bus.imd_val_d[0] = 34'h3_FFFF_FFFF;
    @(negedge clk);
    chk("fl_div_en_off", bus.div_en, 0);
    chk("fl_mult_en_off", bus.mult_en, 0);
    chk("fl_ex_ready", bus.ex_ready, 0);
    chk("fl_mdrdy", bus.multdiv_ready_id, 0);
    cyc(); clr_in();
    @(negedge clk);
    chk("fl_no_wb", bus.wb_valid, 0);
    chk("fl_vxsat", bus.vxsat, 0);
    chk("fl_imd0", bus.imd_val_q[0], 34'h1_0000_0001);
    chk("fl_idle", bus.ex_ready, 1);

    // ov capture beats simultaneous CSR write of 0
    cyc(); clr_in();
    issue_single(32'h1234_5678, 5'd7, 1'b1);
    bus.vxsat_we = 1'b1; bus.vxsat_wdata = 1'b0;
    sb.push_back('{32'h1234_5678, 5'd7, 1'b1});
    cyc(); clr_in();
    @(negedge clk);
    chk("csr_ov_vxsat", bus.vxsat, 1);

    // backpressure then back-to-back accept
    cyc(); clr_in();
    issue_single(32'hCAFE_0001, 5'd11, 1'b0);
    bus.wb_ready = 1'b0;
    sb.push_back('{32'hCAFE_0001, 5'd11, 1'b1});
    for (int i = 0; i < 5; i++) begin
      cyc();
      issue_single(32'hCAFE_0002, 5'd12, 1'b0);
      bus.wb_ready = 1'b0;
      @(negedge clk);
      chk("bp_wb_valid", bus.wb_valid, 1);
      chk("bp_result", bus.wb_result, 32'hCAFE_0001);
      chk("bp_rd", bus.wb_rd_addr, 5'd11);
      chk("bp_ex_ready", bus.ex_ready, 0);
    end
    cyc();
    issue_single(32'hCAFE_0002, 5'd12, 1'b0);
    bus.wb_ready = 1'b1;
    sb.push_back('{32'hCAFE_0002, 5'd12, 1'b1});
    @(negedge clk);
    chk("b2b_ex_ready", bus.ex_ready, 1);
    cyc(); clr_in();
    @(negedge clk);
    chk("b2b_wb_valid", bus.wb_valid, 1);
    chk("b2b_result", bus.wb_result, 32'hCAFE_0002);

    // watchdog
    cyc(); clr_in();
    bus.instr_valid = 1'b1; bus.instr_multicycle = 1'b1; bus.mult_sel = 1'b1; bus.rd_addr = 5'd20;
    n = 0; seen = 1'b0; wbseen = 1'b0;
    for (int i = 0; i < 3 * MAXC; i++) begin
      cyc(); clr_in();
      @(negedge clk);
      if (bus.timeout) begin
        seen = 1'b1;
        break;
      end
      if (bus.wb_valid) wbseen = 1'b1;
      n++;
    end
    chk("wd_seen", seen, 1);
    chk("wd_cycles", n, MAXC);
    chk("wd_no_wb", wbseen, 0);
    chk("wd_wb_valid", bus.wb_valid, 0);
    chk("wd_idle", bus.ex_ready, 1);
    chk("wd_mult_en", bus.mult_en, 0);
    cyc(); clr_in();
    @(negedge clk);
    chk("wd_pulse_end", bus.timeout, 0);

    // asynchronous reset mid-operation
    cyc(); clr_in();
    bus.instr_valid = 1'b1; bus.instr_multicycle = 1'b1; bus.div_sel = 1'b1; bus.rd_addr = 5'd4;
    bus.imd_val_we = 2'b11; bus.imd_val_d[0] = 34'h0_1111_2222; bus.imd_val_d[1] = 34'h0_3333_4444;
    cyc(); clr_in();
    @(negedge clk);
    chk("rm_imd1", bus.imd_val_q[1], 34'h0_3333_4444);
    chk("rm_div_en", bus.div_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_imd", bus.imd_val_q, 0);
    chk("rm_div_en_off", bus.div_en, 0);
    chk("rm_ex_ready", bus.ex_ready, 1);
    chk("rm_vxsat", bus.vxsat, 0);
    cyc();
    rst_n = 1'b1;
    cyc(); clr_in();
    issue_single(32'h0000_0042, 5'd1, 1'b0);
    sb.push_back('{32'h0000_0042, 5'd1, 1'b0});
    cyc(); clr_in();
    @(negedge clk);
    chk("post_rst_wb", bus.wb_valid, 1);

    repeat (3) cyc();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
